// File: rtl/jtag_pa.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pa (package)
//  Description : Shared JTAG definitions. Holds the scan register width, the
//                default length of the TMS=1 reset preamble and the TAP state
//                enumeration used by both the host scan engine and the TAP FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_pa;

    // Width of the IR and of the USER data register.
    localparam int REG_W = 8;

    // Five TMS=1 clocks drive any TAP into Test-Logic-Reset from any state.
    localparam int RESET_TMS_CYCLES_DEFAULT = 5;

    // Reduced TAP state set: only the states a single RTI-to-RTI scan visits.
    // CAPTURE/SHIFT/EXIT1/UPDATE are shared between the DR and IR branches;
    // which branch is being walked is held separately by the scan engine.
    typedef enum logic [2:0] {
        TAP_TLR     = 3'd0,
        TAP_RTI     = 3'd1,
        TAP_SEL_DR  = 3'd2,
        TAP_SEL_IR  = 3'd3,
        TAP_CAPTURE = 3'd4,
        TAP_SHIFT   = 3'd5,
        TAP_EXIT1   = 3'd6,
        TAP_UPDATE  = 3'd7
    } tap_state_t;

endpackage : jtag_pa
`default_nettype wire

// File: rtl/jtag_host.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_host
//  Description : Host-side JTAG scan engine. Runs one complete IR or DR scan of
//                REG_W bits per request, from Run-Test/Idle back to
//                Run-Test/Idle, and returns the TDO bits captured in Shift.
//  Ports       : i_tclk   - scan clock (all state changes on posedge)
//                i_trst_n - asynchronous active-low reset, aborts any scan
//                i_start  - request pulse, accepted only while o_busy=0
//                i_isIr   - 1 = IR scan, 0 = DR scan (sampled with i_start)
//                i_data   - bits to shift out on TDI, LSB first
//                o_busy   - high from reset / acceptance until scan completion
//                o_done   - one-cycle pulse in the first RTI cycle after a scan
//                o_data   - captured TDO bits, first captured bit in bit 0
//                o_tms, o_tdi - TAP control/data lines, i_tdo - TAP data out
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_host
    import jtag_pa::*;
#(
    // Must be at least 5 so the TAP reaches Test-Logic-Reset from any state.
    parameter int RESET_TMS_CYCLES = RESET_TMS_CYCLES_DEFAULT
) (
    input  logic             i_tclk,
    input  logic             i_trst_n,
    input  logic             i_start,
    input  logic             i_isIr,
    input  logic [REG_W-1:0] i_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [REG_W-1:0] o_data,
    output logic             o_tms,
    output logic             o_tdi,
    input  logic             i_tdo
);

    localparam int CNT_W = (REG_W > 1) ? $clog2(REG_W) : 1;
    localparam int RST_W = $clog2(RESET_TMS_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(REG_W - 1);
    localparam logic [RST_W-1:0] C_RST_LAST = RST_W'(RESET_TMS_CYCLES);

    // The state register tracks the TAP's own state cycle for cycle.
    tap_state_t         r_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [REG_W-1:0]   r_shreg;
    logic               r_req;
    logic               r_is_ir;
    logic               r_done;
    logic [REG_W-1:0]   r_data;

    logic               w_tms;

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_state   <= TAP_TLR;
            r_rst_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_req     <= 1'b0;
            r_is_ir   <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TAP_TLR: begin
                    // Count the TMS=1 preamble; the final TLR cycle drives
                    // TMS=0 so the TAP follows us into RTI.
                    if (r_rst_cnt < C_RST_LAST) begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end else begin
                        r_state <= TAP_RTI;
                    end
                end
                TAP_RTI: begin
                    // Acceptance only latches the request; the TAP leaves
                    // RTI on the following edge, when TMS=1 is already driven.
                    if (r_req) begin
                        r_state <= TAP_SEL_DR;
                    end else if (i_start) begin
                        r_req   <= 1'b1;
                        r_is_ir <= i_isIr;
                        r_shreg <= i_data;
                    end
                end
                TAP_SEL_DR: begin
                    r_state <= r_is_ir ? TAP_SEL_IR : TAP_CAPTURE;
                end
                TAP_SEL_IR: begin
                    r_state <= TAP_CAPTURE;
                end
                TAP_CAPTURE: begin
                    r_bit_cnt <= '0;
                    r_state   <= TAP_SHIFT;
                end
                TAP_SHIFT: begin
                    // TDO enters at the top while TDI leaves from bit 0, so
                    // after REG_W shifts the first captured bit sits in bit 0.
                    r_shreg   <= {i_tdo, r_shreg[REG_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == C_LAST_BIT) begin
                        r_state <= TAP_EXIT1;
                    end
                end
                TAP_EXIT1: begin
                    r_state <= TAP_UPDATE;
                end
                TAP_UPDATE: begin
                    r_state <= TAP_RTI;
                    r_req   <= 1'b0;
                    r_data  <= r_shreg;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= TAP_TLR;
                end
            endcase
        end
    end

    // TMS is a pure decode of registered state, so a request never reaches
    // the TAP combinationally.
    always_comb begin
        w_tms = 1'b0;
        case (r_state)
            TAP_TLR:     w_tms = (r_rst_cnt < C_RST_LAST);
            TAP_RTI:     w_tms = r_req;
            TAP_SEL_DR:  w_tms = r_is_ir;
            TAP_SEL_IR:  w_tms = 1'b0;
            TAP_CAPTURE: w_tms = 1'b0;
            TAP_SHIFT:   w_tms = (r_bit_cnt == C_LAST_BIT);
            TAP_EXIT1:   w_tms = 1'b1;
            TAP_UPDATE:  w_tms = 1'b0;
            default:     w_tms = 1'b1;
        endcase
    end

    assign o_tms  = w_tms;
    assign o_tdi  = (r_state == TAP_SHIFT) && r_shreg[0];
    assign o_busy = (r_state != TAP_RTI) || r_req;
    assign o_done = r_done;
    assign o_data = r_data;

endmodule : jtag_host
`default_nettype wire

// File: tb/tb_jtag_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_host
//  Description : Self-checking bench for jtag_host. A behavioural 16-state TAP
//                with an IR and one DR sits on the far side of the link. The
//                driver pushes the expected result of every accepted request
//                into a queue; a monitor pops and compares on each o_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_host;
    import jtag_pa::*;

    localparam logic [REG_W-1:0] C_DR_INIT   = REG_W'('h3C);
    localparam logic [REG_W-1:0] C_IR_CAPT   = REG_W'('h01);
    localparam logic [REG_W-1:0] C_IR_INIT   = REG_W'('h01);

    // Full IEEE 1149.1 TAP state numbering for the reference TAP.
    localparam int T_TLR = 0,  T_RTI = 1,  T_SDR = 2,  T_CDR = 3;
    localparam int T_SHD = 4,  T_E1D = 5,  T_PDR = 6,  T_E2D = 7;
    localparam int T_UDR = 8,  T_SIR = 9,  T_CIR = 10, T_SHI = 11;
    localparam int T_E1I = 12, T_PIR = 13, T_E2I = 14, T_UIR = 15;

    logic             i_tclk;
    logic             i_trst_n;
    logic             i_start;
    logic             i_isIr;
    logic [REG_W-1:0] i_data;
    logic             o_busy;
    logic             o_done;
    logic [REG_W-1:0] o_data;
    logic             o_tms;
    logic             o_tdi;
    logic             i_tdo;

    jtag_host #(.RESET_TMS_CYCLES(RESET_TMS_CYCLES_DEFAULT)) dut (
        .i_tclk   (i_tclk),
        .i_trst_n (i_trst_n),
        .i_start  (i_start),
        .i_isIr   (i_isIr),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_data   (o_data),
        .o_tms    (o_tms),
        .o_tdi    (o_tdi),
        .i_tdo    (i_tdo)
    );

    initial i_tclk = 1'b0;
    always #5 i_tclk = ~i_tclk;

    int cyc = 0;
    always @(posedge i_tclk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference TAP
    // ------------------------------------------------------------------
    int               tap_st;
    logic [REG_W-1:0] dr_hold, dr_sh, ir_hold, ir_sh;

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            T_TLR: return tms ? T_TLR : T_RTI;
            T_RTI: return tms ? T_SDR : T_RTI;
            T_SDR: return tms ? T_SIR : T_CDR;
            T_CDR: return tms ? T_E1D : T_SHD;
            T_SHD: return tms ? T_E1D : T_SHD;
            T_E1D: return tms ? T_UDR : T_PDR;
            T_PDR: return tms ? T_E2D : T_PDR;
            T_E2D: return tms ? T_UDR : T_SHD;
            T_UDR: return tms ? T_SDR : T_RTI;
            T_SIR: return tms ? T_TLR : T_CIR;
            T_CIR: return tms ? T_E1I : T_SHI;
            T_SHI: return tms ? T_E1I : T_SHI;
            T_E1I: return tms ? T_UIR : T_PIR;
            T_PIR: return tms ? T_E2I : T_PIR;
            T_E2I: return tms ? T_UIR : T_SHI;
            T_UIR: return tms ? T_SDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            tap_st  <= T_TLR;
            dr_hold <= C_DR_INIT;
            ir_hold <= C_IR_INIT;
            dr_sh   <= '0;
            ir_sh   <= '0;
        end else begin
            case (tap_st)
                T_CDR: dr_sh   <= dr_hold;
                T_SHD: dr_sh   <= {o_tdi, dr_sh[REG_W-1:1]};
                T_UDR: dr_hold <= dr_sh;
                T_CIR: ir_sh   <= C_IR_CAPT;
                T_SHI: ir_sh   <= {o_tdi, ir_sh[REG_W-1:1]};
                T_UIR: ir_hold <= ir_sh;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, o_tms);
        end
    end

    assign i_tdo = (tap_st == T_SHD) ? dr_sh[0] :
                   (tap_st == T_SHI) ? ir_sh[0] : 1'b0;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic             is_ir;
        logic [REG_W-1:0] data;
        logic [REG_W-1:0] exp_cap;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];

    // Monitor: every o_done must match the oldest outstanding request.
    always @(negedge i_tclk) begin
        if (i_trst_n && o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("scan_o_data", 32'(o_data), 32'(e.exp_cap));
                check("done_latency", 32'(cyc - e.acc_cyc),
                      32'(e.is_ir ? REG_W + 6 : REG_W + 5));
                check("tap_reg_updated", 32'(e.is_ir ? ir_hold : dr_hold), 32'(e.data));
                check("tap_in_rti", 32'(tap_st), 32'(T_RTI));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (all called at a negedge)
    // ------------------------------------------------------------------
    task automatic issue(input logic ir, input logic [REG_W-1:0] d, output logic acc);
        exp_t e;
        i_start = 1'b1;
        i_isIr  = ir;
        i_data  = d;
        acc     = !o_busy;
        if (acc) begin
            e.is_ir   = ir;
            e.data    = d;
            e.exp_cap = ir ? C_IR_CAPT : dr_hold;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge i_tclk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 300) begin
            @(negedge i_tclk);
            n++;
        end
        if (o_busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge i_tclk);
            n++;
        end while (!o_done && n < 300);
        if (!o_done) check("done_timeout", 32'd1, 32'd0);
    endtask

    // Entered at the negedge where reset has just been released.
    task automatic reset_seq_check();
        for (int i = 0; i <= RESET_TMS_CYCLES_DEFAULT; i++) begin
            check("rst_tms", 32'(o_tms), 32'(i < RESET_TMS_CYCLES_DEFAULT));
            check("rst_busy", 32'(o_busy), 32'd1);
            @(negedge i_tclk);
        end
        check("rst_busy_drop", 32'(o_busy), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_done", 32'(o_done), 32'd0);
        check("rst_tap_rti", 32'(tap_st), 32'(T_RTI));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   mode;
        i_trst_n = 1'b0;
        i_start  = 1'b0;
        i_isIr   = 1'b0;
        i_data   = '0;
        repeat (2) @(negedge i_tclk);

        check("reset_tms", 32'(o_tms), 32'd1);
        check("reset_tdi", 32'(o_tdi), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd1);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_data", 32'(o_data), 32'd0);

        i_trst_n = 1'b1;
        reset_seq_check();

        // Directed DR scan against a TAP holding 0x3C.
        issue(1'b0, REG_W'('hA5), acc);
        check("dr_accept", 32'(acc), 32'd1);
        wait_idle();

        // Directed IR scan.
        issue(1'b1, REG_W'('h02), acc);
        check("ir_accept", 32'(acc), 32'd1);
        wait_idle();

        // Request while mid-SHIFT must be dropped.
        issue(1'b0, REG_W'('h5A), acc);
        check("dr2_accept", 32'(acc), 32'd1);
        repeat (5) @(negedge i_tclk);
        issue(1'b0, {REG_W{1'b1}}, acc);
        check("midshift_ignored", 32'(acc), 32'd0);

        // Back-to-back: new request issued in the o_done cycle.
        wait_done();
        issue(1'b1, REG_W'($urandom), acc);
        check("b2b_accept", 32'(acc), 32'd1);
        wait_done();
        issue(1'b0, REG_W'($urandom), acc);
        check("b2b_accept2", 32'(acc), 32'd1);

        // Randomised mix of idle-gap, back-to-back and ignored requests.
        for (int k = 0; k < 16; k++) begin
            mode = $urandom_range(0, 2);
            if (mode == 1) begin
                wait_done();
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge i_tclk);
            end
            issue(1'($urandom), REG_W'($urandom), acc);
            check("rand_accept", 32'(acc), 32'd1);
            if (mode == 2) begin
                repeat ($urandom_range(0, 9)) @(negedge i_tclk);
                issue(1'($urandom), REG_W'($urandom), acc);
                check("rand_ignored", 32'(acc), 32'd0);
            end
        end
        wait_idle();
        repeat (3) @(negedge i_tclk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Abort at SHIFT bit 3.
        issue(1'b0, REG_W'('hC3), acc);
        check("abort_accept", 32'(acc), 32'd1);
        repeat (6) @(negedge i_tclk);
        check("abort_in_shift", 32'(tap_st), 32'(T_SHD));
        i_trst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_tms", 32'(o_tms), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd1);
        check("abort_done", 32'(o_done), 32'd0);
        @(negedge i_tclk);
        @(negedge i_tclk);
        check("abort_data", 32'(o_data), 32'd0);
        i_trst_n = 1'b1;
        reset_seq_check();
        repeat (4) @(negedge i_tclk);
        check("abort_no_done", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_jtag_host
`default_nettype wire

// File: doc/jtag_host.md
# jtag_host

JTAG host-side scan engine: drives o_tms/o_tdi and samples i_tdo to run complete IR or DR scans of REG_W bits on a JTAG TAP in the same design. It sits on the opposite end of the TCK/TMS/TDI/TDO link from the TAP/data-register logic. It is used for on-chip loopback testing and for a system controller writing and reading the TAP's USER register. Each request is one scan from Run-Test/Idle back to Run-Test/Idle, with captured TDO data returned.

## Interface
- RESET_TMS_CYCLES, 5: number of TMS=1 cycles driven after reset before entering Run-Test/Idle; must be ≥5.
- REG_W comes from jtag_pa; it is not a parameter.
- i_tclk  in  1  scan clock; all state changes on posedge.
- i_trst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request pulse; accepted only when o_busy=0.
- i_isIr  in  1  sampled with i_start; 1 = IR scan, 0 = DR scan.
- i_data  in  REG_W  data to shift out on TDI, LSB first; sampled with i_start.
- o_busy  out  1  high from reset or request acceptance until scan completion.
- o_done  out  1  one-cycle pulse in the first Run-Test/Idle cycle after a scan.
- o_data  out  REG_W  TDO bits captured during the last Shift state; first captured bit ends in bit 0.
- o_tms  out  1  TMS to TAP.
- o_tdi  out  1  TDI to TAP.
- i_tdo  in  1  TDO from TAP.

## Operation
- The FSM mirrors the TAP controller. States are TLR, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE. The state register always equals the TAP's current state.
- o_tms and o_tdi are Moore outputs decoded from the registered state, bit counter, shift register and req flag. There is no combinational path from i_start.
- TLR: tms=1 while rstCnt < RESET_TMS_CYCLES (rstCnt increments each cycle). Then tms=0 and the FSM goes to RTI.
- RTI, req=0: tms=0. If i_start=1, latch i_isIr into isIr_q, latch i_data into shreg, and set req=1. The state stays RTI.
- RTI, req=1: tms=1, go to SEL_DR.
- SEL_DR: tms=isIr_q. Go to SEL_IR if isIr_q=1, else to CAPTURE.
- SEL_IR: tms=0, go to CAPTURE.
- CAPTURE: tms=0, go to SHIFT, bitCnt=0.
- SHIFT: o_tdi=shreg[0]; tms=(bitCnt==REG_W-1).
  - Each posedge: shreg <= {i_tdo, shreg[REG_W-1:1]}; bitCnt++.
  - On the last bit, go to EXIT1.
- EXIT1: tms=1, go to UPDATE.
- UPDATE: tms=0, go to RTI. Clear req, load o_data <= shreg, set o_done=1 for one cycle.
- o_tdi=0 in every state except SHIFT.
- o_busy = (state != RTI) || req.
- i_start while o_busy=1 is ignored, with no queueing.
- i_start in the o_done cycle is accepted, so back-to-back scans are allowed.
- i_trst_n low at any point, including mid-SHIFT, aborts the scan:
  - state=TLR, rstCnt=0, req=0, shreg=0, o_done=0.
  - o_data keeps value 0 from reset; there is no partial update.

## Timing
- Reset values: state TLR, o_tms=1, o_tdi=0, o_busy=1, o_done=0, o_data=0.
- After reset release: TMS=1 for RESET_TMS_CYCLES cycles, then 1 cycle of TMS=0. o_busy falls in the first RTI cycle.
- Acceptance edge E0. TMS sequence driven from the cycle after E0:
  - DR scan: 1, 0, 0, then REG_W SHIFT cycles (last with TMS=1), then 1, 0.
  - IR scan: 1, 1, 0, 0, then the same.
- o_done is high in the cycle after edge E0+REG_W+5 (DR) or E0+REG_W+6 (IR).
- TDI bit k is valid throughout SHIFT cycle k.
- i_tdo must be stable at the posedge that ends each SHIFT cycle. Exactly REG_W samples are taken.
- o_data changes only at the UPDATE→RTI edge.

## Structure
- jtag_pa additions:
  - tap state enum (shared with TAP FSM).
  - RESET_TMS_CYCLES default constant.
- REG_W is reused from jtag_pa.
- Single module, no sub-module.
- Bit counter width: $clog2(REG_W). rstCnt width: $clog2(RESET_TMS_CYCLES+1).

## Test plan
Values are for REG_W=8; scale for other widths.
- Reset release: o_tms=1 for 5 cycles then 0, o_busy drops after 6 cycles, o_data=0, o_done=0.
- DR scan, i_data=0xA5, TDO looped from a TAP model holding 0x3C: o_tdi sequence 1,0,1,0,0,1,0,1. o_data=0x3C at o_done, with o_done 13 cycles after acceptance. TAP model updates its DR to 0xA5.
- IR scan, i_isIr=1, i_data=0x02: TMS sequence 1,1,0,0,0×7,1,1,0. TAP IR becomes 0x02. o_done 14 cycles after acceptance.
- i_start pulsed mid-SHIFT with i_data=0xFF: ignored. The current scan completes unchanged and no second o_done occurs.
- i_start held high in the o_done cycle: a second scan starts with no idle gap beyond RTI. Two o_done pulses occur with correct o_data each.
- i_trst_n asserted at SHIFT bit 3: o_tms=1, o_busy=1, o_done never pulses, and the reset sequence restarts; the TAP model ends in RTI.
